riscv_pipe_ctrl: RTL and testbench
==================================

Name: riscv_pipe_ctrl

Overview:
- Parametrised pipeline control unit for the RV32I core. It replaces the fixed hazard detection, forwarding and flush logic with one block scaled by back-end stage count and load latency.
- Tracks every in-flight instruction past ID in an internal scoreboard shift register.
- From that state it generates IF/ID stall, EX bubble, IF/ID flush and per-operand forward selects for the decode stage, plus saturating hazard counters.
- Sits beside the ID stage. It is driven by the decode fields, the branch/jump unit and the data-memory stall.

Parameters:
- NB_OPERAND, 5, register index width.
- N_STAGES, 3, tracked stages after ID; stage 1=EX, 2=MEM, 3=WB. Range 2..6.
- LOAD_STAGE, 2, first stage whose combinational output carries load data. Range 1..N_STAGES.
- NB_CNT, 16, width of the performance counters.
- NB_SEL, $clog2(N_STAGES+1), width of the forward selects (derived).

Ports:
- i_clock  in  1  core clock
- i_reset_n  in  1  asynchronous active-low reset
- i_id_valid  in  1  ID holds a real instruction
- i_id_rs1  in  NB_OPERAND  ID source register 1
- i_id_rs2  in  NB_OPERAND  ID source register 2
- i_id_use_rs1  in  1  instruction reads rs1
- i_id_use_rs2  in  1  instruction reads rs2
- i_id_rd  in  NB_OPERAND  ID destination register
- i_id_rf_wr  in  1  instruction writes RF
- i_id_is_load  in  1  instruction is a load
- i_branch_taken  in  1  branch/jump resolved taken in ID
- i_ext_stall  in  1  dmem not ready; freeze whole pipeline
- o_stall_if  out  1  hold PC and IF/ID register
- o_bubble_ex  out  1  load zero control bus into ID/EX
- o_flush_if_id  out  1  squash IF/ID contents
- o_fwd_rs1  out  NB_SEL  0=RF, k=stage k output
- o_fwd_rs2  out  NB_SEL  as o_fwd_rs1
- o_stage_valid  out  N_STAGES  per-stage valid, bit k-1 = stage k
- o_load_stall_cnt  out  NB_CNT  cycles lost to load-use hazards
- o_flush_cnt  out  NB_CNT  taken-branch flushes

Behaviour:
- State: entry[1..N_STAGES] = {valid, rd, rf_wr, is_load}.
- Reset (async, i_reset_n=0): all entries invalid, fields 0, counters 0.
  - With no ID inputs active, all outputs are 0 after reset.
  - Reset mid-operation discards all in-flight entries immediately.
- Match for source s (rs1 or rs2): requires use=1, rs!=0, i_id_valid=1.
  - Youngest k (smallest index) with entry[k].valid && rf_wr && rd==rs.
  - rs==0 never matches.
- Forward select: o_fwd_rsX = k if a match exists and the hazard condition below is false, else 0. It is purely combinational.
- Load hazard (lh): any source matches at k with entry[k].is_load && k < LOAD_STAGE.
- Priority, highest first:
  1. i_ext_stall=1:
     - o_stall_if=1, o_bubble_ex=0, o_flush_if_id=0.
     - Entries hold and counters hold.
     - Forward selects stay valid against the held state.
  2. lh=1:
     - o_stall_if=1, o_bubble_ex=1, o_flush_if_id=0 (any branch in ID re-resolves next cycle).
     - entry[1] <= invalid, entry[k] <= entry[k-1].
     - load_stall_cnt++.
  3. i_branch_taken=1:
     - o_flush_if_id=1, o_stall_if=0, o_bubble_ex=0.
     - The branch itself enters entry[1].
     - flush_cnt++.
  4. Otherwise: entry[1] <= ID fields, valid = i_id_valid; entry[k] <= entry[k-1].
- The entry leaving stage N_STAGES is discarded. The RF write happens that cycle, so forward sel=N_STAGES covers the write/read same-cycle case.
- Counters saturate at all-ones and do not wrap.
- Multi-cycle load stall: lh deasserts once the load reaches LOAD_STAGE.
  - Stall length = LOAD_STAGE - k cycles.
  - With defaults, a load immediately followed by a dependent instruction stalls 1 cycle.
- Latency: all control outputs are combinational from the current entries and ID inputs. Scoreboard update takes 1 cycle.

Test Plan:
- Reset: hold i_reset_n=0 for 3 cycles, then release with i_id_valid=0 -> o_stage_valid=000, all outputs 0, counters 0.
- ALU forwarding: issue rd=5 rf_wr, then next cycle rs1=5 -> o_fwd_rs1=1. With one independent instruction between -> o_fwd_rs1=2. With two between -> 3. With three between -> 0.
- Load-use: issue load rd=7, next instruction uses rs2=7 -> o_stall_if=1, o_bubble_ex=1 for exactly 1 cycle, then o_fwd_rs2=2. o_load_stall_cnt=1.
- Branch vs hazard: i_branch_taken=1 while lh=1 -> o_flush_if_id=0. The next cycle, with lh cleared and branch still taken -> o_flush_if_id=1, o_flush_cnt=1.
- Ext stall: assert i_ext_stall for 4 cycles while a load hazard is pending -> entries frozen, o_load_stall_cnt unchanged, o_stall_if=1. Deassert -> hazard resolves as in the load-use scenario.
- x0 and saturation: rd=0 write followed by rs1=0 use -> o_fwd_rs1=0, no stall. Force 2^NB_CNT+3 flushes -> o_flush_cnt=all-ones.

Source files
------------

// File: rtl/riscv_pipe_ctrl.sv
// Pipeline control for the RV32I core: in-flight scoreboard, load-use stall,
// taken-branch flush, operand forward selects and saturating hazard counters.
module riscv_pipe_ctrl #(
  parameter int NB_OPERAND = 5,
  parameter int N_STAGES   = 3,
  parameter int LOAD_STAGE = 2,
  parameter int NB_CNT     = 16,
  parameter int NB_SEL     = $clog2(N_STAGES + 1)
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_id_valid,
  input  logic [NB_OPERAND-1:0] i_id_rs1,
  input  logic [NB_OPERAND-1:0] i_id_rs2,
  input  logic                  i_id_use_rs1,
  input  logic                  i_id_use_rs2,
  input  logic [NB_OPERAND-1:0] i_id_rd,
  input  logic                  i_id_rf_wr,
  input  logic                  i_id_is_load,
  input  logic                  i_branch_taken,
  input  logic                  i_ext_stall,
  output logic                  o_stall_if,
  output logic                  o_bubble_ex,
  output logic                  o_flush_if_id,
  output logic [NB_SEL-1:0]     o_fwd_rs1,
  output logic [NB_SEL-1:0]     o_fwd_rs2,
  output logic [N_STAGES-1:0]   o_stage_valid,
  output logic [NB_CNT-1:0]     o_load_stall_cnt,
  output logic [NB_CNT-1:0]     o_flush_cnt
);

  // Entry k (stage k) lives at index k-1; index 0 is EX.
  logic [N_STAGES-1:0]                 valid_r;
  logic [N_STAGES-1:0]                 rf_wr_r;
  logic [N_STAGES-1:0]                 is_load_r;
  logic [N_STAGES-1:0][NB_OPERAND-1:0] rd_r;
  logic [NB_CNT-1:0]                   load_stall_cnt_r;
  logic [NB_CNT-1:0]                   flush_cnt_r;

  logic [NB_SEL:0] match_rs1_s;
  logic [NB_SEL:0] match_rs2_s;
  logic            lh_s;

  // Returns {load_hazard, stage}; scanning oldest to youngest lets the youngest writer win.
  function automatic logic [NB_SEL:0] find_match(
    input logic [NB_OPERAND-1:0]               rs,
    input logic                                use_rs,
    input logic                                id_valid,
    input logic [N_STAGES-1:0]                 valid,
    input logic [N_STAGES-1:0]                 rf_wr,
    input logic [N_STAGES-1:0]                 is_load,
    input logic [N_STAGES-1:0][NB_OPERAND-1:0] rd
  );
    logic [NB_SEL-1:0] sel;
    logic              hz;
    sel = '0;
    hz  = 1'b0;
    for (int k = N_STAGES; k >= 1; k--) begin
      if (use_rs && id_valid && (rs != '0) && valid[k-1] && rf_wr[k-1] && (rd[k-1] == rs)) begin
        sel = NB_SEL'(k);
        hz  = is_load[k-1] && (k < LOAD_STAGE);
      end else begin
        sel = sel;
        hz  = hz;
      end
    end
    return {hz, sel};
  endfunction

  assign match_rs1_s = find_match(i_id_rs1, i_id_use_rs1, i_id_valid, valid_r, rf_wr_r, is_load_r, rd_r);
  assign match_rs2_s = find_match(i_id_rs2, i_id_use_rs2, i_id_valid, valid_r, rf_wr_r, is_load_r, rd_r);
  assign lh_s        = match_rs1_s[NB_SEL] | match_rs2_s[NB_SEL];

  // Control outputs in priority order: external stall, load hazard, taken branch.
  always_comb begin
    o_stall_if    = 1'b0;
    o_bubble_ex   = 1'b0;
    o_flush_if_id = 1'b0;
    if (i_ext_stall) begin
      o_stall_if = 1'b1;
    end else if (lh_s) begin
      o_stall_if  = 1'b1;
      o_bubble_ex = 1'b1;
    end else if (i_branch_taken) begin
      o_flush_if_id = 1'b1;
    end else begin
      o_stall_if    = 1'b0;
      o_bubble_ex   = 1'b0;
      o_flush_if_id = 1'b0;
    end
  end

  // Forwarding from a load still short of its data stage is suppressed while the hazard stands.
  always_comb begin
    o_fwd_rs1 = '0;
    o_fwd_rs2 = '0;
    if (lh_s) begin
      o_fwd_rs1 = '0;
      o_fwd_rs2 = '0;
    end else begin
      o_fwd_rs1 = match_rs1_s[NB_SEL-1:0];
      o_fwd_rs2 = match_rs2_s[NB_SEL-1:0];
    end
  end

  // Scoreboard shift register; the oldest entry drops off the end as it writes the RF.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid_r   <= '0;
      rf_wr_r   <= '0;
      is_load_r <= '0;
      rd_r      <= '0;
    end else if (i_ext_stall) begin
      valid_r   <= valid_r;
      rf_wr_r   <= rf_wr_r;
      is_load_r <= is_load_r;
      rd_r      <= rd_r;
    end else if (lh_s) begin
      valid_r   <= {valid_r[N_STAGES-2:0], 1'b0};
      rf_wr_r   <= {rf_wr_r[N_STAGES-2:0], 1'b0};
      is_load_r <= {is_load_r[N_STAGES-2:0], 1'b0};
      rd_r      <= {rd_r[N_STAGES-2:0], {NB_OPERAND{1'b0}}};
    end else begin
      valid_r   <= {valid_r[N_STAGES-2:0], i_id_valid};
      rf_wr_r   <= {rf_wr_r[N_STAGES-2:0], i_id_rf_wr};
      is_load_r <= {is_load_r[N_STAGES-2:0], i_id_is_load};
      rd_r      <= {rd_r[N_STAGES-2:0], i_id_rd};
    end
  end

  // Saturating hazard counters, frozen under external stall.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      load_stall_cnt_r <= '0;
      flush_cnt_r      <= '0;
    end else if (i_ext_stall) begin
      load_stall_cnt_r <= load_stall_cnt_r;
      flush_cnt_r      <= flush_cnt_r;
    end else if (lh_s) begin
      load_stall_cnt_r <= (load_stall_cnt_r == '1) ? load_stall_cnt_r : load_stall_cnt_r + NB_CNT'(1);
      flush_cnt_r      <= flush_cnt_r;
    end else if (i_branch_taken) begin
      load_stall_cnt_r <= load_stall_cnt_r;
      flush_cnt_r      <= (flush_cnt_r == '1) ? flush_cnt_r : flush_cnt_r + NB_CNT'(1);
    end else begin
      load_stall_cnt_r <= load_stall_cnt_r;
      flush_cnt_r      <= flush_cnt_r;
    end
  end

  assign o_stage_valid    = valid_r;
  assign o_load_stall_cnt = load_stall_cnt_r;
  assign o_flush_cnt      = flush_cnt_r;

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Scoreboard bench for riscv_pipe_ctrl: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT each cycle.
module tb_riscv_pipe_ctrl;

  localparam int NB_OPERAND = 5;
  localparam int N_STAGES   = 3;
  localparam int NB_CNT     = 16;
  localparam int NB_SEL     = 2;
  localparam int SAT        = 65535;

  logic                  i_clock;
  logic                  i_reset_n;
  logic                  i_id_valid;
  logic [NB_OPERAND-1:0] i_id_rs1;
  logic [NB_OPERAND-1:0] i_id_rs2;
  logic                  i_id_use_rs1;
  logic                  i_id_use_rs2;
  logic [NB_OPERAND-1:0] i_id_rd;
  logic                  i_id_rf_wr;
  logic                  i_id_is_load;
  logic                  i_branch_taken;
  logic                  i_ext_stall;
  logic                  o_stall_if;
  logic                  o_bubble_ex;
  logic                  o_flush_if_id;
  logic [NB_SEL-1:0]     o_fwd_rs1;
  logic [NB_SEL-1:0]     o_fwd_rs2;
  logic [N_STAGES-1:0]   o_stage_valid;
  logic [NB_CNT-1:0]     o_load_stall_cnt;
  logic [NB_CNT-1:0]     o_flush_cnt;

  riscv_pipe_ctrl dut (
    .i_clock          (i_clock),
    .i_reset_n        (i_reset_n),
    .i_id_valid       (i_id_valid),
    .i_id_rs1         (i_id_rs1),
    .i_id_rs2         (i_id_rs2),
    .i_id_use_rs1     (i_id_use_rs1),
    .i_id_use_rs2     (i_id_use_rs2),
    .i_id_rd          (i_id_rd),
    .i_id_rf_wr       (i_id_rf_wr),
    .i_id_is_load     (i_id_is_load),
    .i_branch_taken   (i_branch_taken),
    .i_ext_stall      (i_ext_stall),
    .o_stall_if       (o_stall_if),
    .o_bubble_ex      (o_bubble_ex),
    .o_flush_if_id    (o_flush_if_id),
    .o_fwd_rs1        (o_fwd_rs1),
    .o_fwd_rs2        (o_fwd_rs2),
    .o_stage_valid    (o_stage_valid),
    .o_load_stall_cnt (o_load_stall_cnt),
    .o_flush_cnt      (o_flush_cnt)
  );

  typedef struct packed {
    logic              stall;
    logic              bubble;
    logic              flush;
    logic [NB_SEL-1:0] fwd1;
    logic [NB_SEL-1:0] fwd2;
    logic [2:0]        sv;
    logic [15:0]       lc;
    logic [15:0]       fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_miss;

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic chk(input string name, input int act, input int want, input int idx);
    if (act != want) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %0d, want %0d", name, idx, act, want);
    end
  endtask

  // Monitor: one expectation per cycle, compared away from the active edge.
  always @(negedge i_clock) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("stall_if",    int'(o_stall_if),       int'(e.stall),  n_vec);
      chk("bubble_ex",   int'(o_bubble_ex),      int'(e.bubble), n_vec);
      chk("flush_if_id", int'(o_flush_if_id),    int'(e.flush),  n_vec);
      chk("fwd_rs1",     int'(o_fwd_rs1),        int'(e.fwd1),   n_vec);
      chk("fwd_rs2",     int'(o_fwd_rs2),        int'(e.fwd2),   n_vec);
      chk("stage_valid", int'(o_stage_valid),    int'(e.sv),     n_vec);
      chk("load_cnt",    int'(o_load_stall_cnt), int'(e.lc),     n_vec);
      chk("flush_cnt",   int'(o_flush_cnt),      int'(e.fc),     n_vec);
      n_vec++;
    end
  end

  task automatic vec(
    input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
    input logic [4:0] rd, input logic wr, input logic ld, input logic br, input logic ext,
    input logic es, input logic eb, input logic ef, input logic [1:0] f1, input logic [1:0] f2,
    input logic [2:0] sv, input int lc, input int fc);
    exp_t e;
    i_id_valid     = v;
    i_id_rs1       = rs1;
    i_id_use_rs1   = u1;
    i_id_rs2       = rs2;
    i_id_use_rs2   = u2;
    i_id_rd        = rd;
    i_id_rf_wr     = wr;
    i_id_is_load   = ld;
    i_branch_taken = br;
    i_ext_stall    = ext;
    e.stall  = es;
    e.bubble = eb;
    e.flush  = ef;
    e.fwd1   = f1;
    e.fwd2   = f2;
    e.sv     = sv;
    e.lc     = 16'(lc);
    e.fc     = 16'(fc);
    exp_q.push_back(e);
    @(posedge i_clock);
    #1;
  endtask

  task automatic idle(input logic [2:0] sv, input int lc, input int fc);
    vec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 2'd0, 2'd0, sv, lc, fc);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    i_reset_n = 1'b0;
    i_id_valid = 1'b0; i_id_rs1 = 5'd0; i_id_rs2 = 5'd0; i_id_use_rs1 = 1'b0;
    i_id_use_rs2 = 1'b0; i_id_rd = 5'd0; i_id_rf_wr = 1'b0; i_id_is_load = 1'b0;
    i_branch_taken = 1'b0; i_ext_stall = 1'b0;
    @(posedge i_clock);
    #1;
    for (int i = 0; i < 3; i++) idle(3'b000, 0, 0);
    i_reset_n = 1'b1;
    idle(3'b000, 0, 0);

    // ALU forwarding distance 1/2/3/none, x0 never forwarded, youngest writer wins
    //   v rs1 u1 rs2 u2 rd wr ld br ext | st bu fl f1 f2 sv lc fc
    vec(1, 0, 0, 0, 0, 5, 1, 0, 0, 0,   0, 0, 0, 0, 0, 3'b000, 0, 0);
    vec(1, 5, 1, 0, 0, 6, 0, 0, 0, 0,   0, 0, 0, 1, 0, 3'b001, 0, 0);
    vec(1, 5, 1, 0, 0, 8, 1, 0, 0, 0,   0, 0, 0, 2, 0, 3'b011, 0, 0);
    vec(1, 5, 1, 8, 1, 9, 0, 0, 0, 0,   0, 0, 0, 3, 1, 3'b111, 0, 0);
    vec(1, 5, 1, 8, 1, 0, 1, 0, 0, 0,   0, 0, 0, 0, 2, 3'b111, 0, 0);
    vec(1, 0, 1, 8, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 3'b111, 0, 0);
    vec(1, 0, 0, 0, 0, 10, 1, 0, 0, 0,  0, 0, 0, 0, 0, 3'b111, 0, 0);
    vec(1, 10, 1, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 1, 0, 3'b111, 0, 0);
    vec(1, 10, 1, 0, 0, 11, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b111, 0, 0);

    // Load-use: one stall cycle, then forward from MEM
    vec(1, 0, 0, 0, 0, 7, 1, 1, 0, 0,   0, 0, 0, 0, 0, 3'b111, 0, 0);
    vec(1, 0, 0, 7, 1, 12, 1, 0, 0, 0,  1, 1, 0, 0, 0, 3'b111, 0, 0);
    vec(1, 0, 0, 7, 1, 12, 1, 0, 0, 0,  0, 0, 0, 0, 2, 3'b110, 1, 0);

    // Branch loses to load hazard, then flushes
    vec(1, 0, 0, 0, 0, 13, 1, 1, 0, 0,  0, 0, 0, 0, 0, 3'b101, 1, 0);
    vec(1, 13, 1, 0, 0, 0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 3'b011, 1, 0);
    vec(1, 13, 1, 0, 0, 0, 0, 0, 1, 0,  0, 0, 1, 2, 0, 3'b110, 2, 0);
    idle(3'b101, 2, 1);

    // External stall over a pending load hazard freezes state and counters
    vec(1, 0, 0, 0, 0, 14, 1, 1, 0, 0,  0, 0, 0, 0, 0, 3'b010, 2, 1);
    vec(1, 14, 1, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 3'b101, 2, 1);
    vec(1, 14, 1, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 3'b101, 2, 1);
    vec(1, 14, 1, 0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0, 3'b101, 2, 1);
    vec(1, 14, 1, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 3'b101, 2, 1);
    vec(1, 14, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 3'b101, 2, 1);
    vec(1, 14, 1, 0, 0, 15, 1, 0, 0, 0, 0, 0, 0, 2, 0, 3'b010, 3, 1);
    vec(1, 14, 1, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 3'b101, 3, 1);
    vec(0, 15, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3'b011, 3, 1);
    idle(3'b110, 3, 1);
    idle(3'b100, 3, 1);
    idle(3'b000, 3, 1);

    // Flush counter saturation: 2^16+3 taken branches
    for (int i = 0; i < 65539; i++) begin
      vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 3'b000, 3,
          ((1 + i) > SAT) ? SAT : (1 + i));
    end
    idle(3'b000, 3, SAT);

    // Mid-operation reset discards the in-flight entry and clears counters
    vec(1, 0, 0, 0, 0, 5, 1, 0, 0, 0,   0, 0, 0, 0, 0, 3'b000, 3, SAT);
    i_reset_n = 1'b0;
    idle(3'b000, 0, 0);
    i_reset_n = 1'b1;
    idle(3'b000, 0, 0);

    repeat (2) @(negedge i_clock);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
